imem_fetch: RTL
===============

// Module: imem_fetch
// PURPOSE
//  Instruction-fetch requester for the single-port BSRAM instruction memory (word-addressed, synchronous read).
//  Sits between the core PC logic and decode.
//  Drives imem_ce/imem_ad, tracks in-flight reads, and buffers returned words with their PCs.
//  Presents words to decode over a valid/ready handshake; a redirect (branch/jump/trap) flushes stale fetches.
// PARAMETERS
//  ADDR_W    11        imem word-address width (2^ADDR_W x 32-bit words)
//  RESET_PC  32'h0     byte PC fetched after reset
// PORTS
//  clk             in   1       single clock
//  reset           in   1       synchronous, active-high reset
//  imem_ce         out  1       read enable to BSRAM (one request per high cycle)
//  imem_oce        out  1       BSRAM output-register enable; constant 1
//  imem_wre        out  1       BSRAM write enable; constant 0
//  imem_ad         out  ADDR_W  word address = pc[ADDR_W+1:2]
//  imem_dout       in   32      BSRAM read data, valid L cycles after request
//  redirect_valid  in   1       load new PC, flush everything
//  redirect_pc     in   32      new byte PC; bits [1:0] ignored (forced 0)
//  if_valid        out  1       if_pc/if_instr hold a fetched word
//  if_ready        in   1       decode accepts word when if_valid&&if_ready
//  if_pc           out  32      byte PC of presented word
//  if_instr        out  32      presented instruction word
// BEHAVIOUR
//  - Read latency L=1 (L=2 with IFETCH_OREG_EN). Buffer depth D=L+1, giving 1 word/cycle sustained.
//  - State: pc (next fetch), inflight shift reg of L valid bits, D-entry FIFO {pc,instr}.
//  - pop   = if_valid && if_ready.
//  - issue = !reset && !redirect_valid && (occ + inflight_cnt - pop < D).
//  - imem_ce = issue; imem_ad = pc[ADDR_W+1:2] (combinational from registered pc).
//  - On issue: pc <= pc+4, wrapping at 2^32; imem_ad wraps naturally at 2^ADDR_W words.
//  - The inflight bit emerging after L cycles pushes {req_pc, imem_dout} into the FIFO; data is captured only on that cycle.
//  - if_valid = FIFO non-empty. if_pc/if_instr come from the FIFO head, registered and stable while !if_ready.
//  - Redirect (priority over all else), same cycle:
//    - no issue; a pop in this cycle still counts as consumed;
//    - at the edge: pc <= {redirect_pc[31:2],2'b00}; FIFO emptied; all inflight bits cleared, so returning data is dropped.
//    - The first request goes out the next cycle; if_valid is low for L+1 cycles.
//  - Reset (any time, including mid-fetch):
//    - if_valid=0, FIFO empty, inflight=0, pc=RESET_PC; imem_ce=0 while reset is high;
//    - if_pc/if_instr=0; imem_oce=1, imem_wre=0 at all times.
//  - First issue is in the cycle reset drops; first if_valid is L+1 cycles later.
//  - FIFO full and !if_ready: no issue; the pop term frees one slot in the same cycle.
//  - Full+pop+push in one cycle is legal; occupancy unchanged.
//  - No duplicates, no skipped PCs outside redirects.
// CONFIGURATION
//  IFETCH_OREG_EN defined: the BSRAM is built with its output register (pipelined read).
//    L=2, D=3, two requests may be outstanding.
//  Undefined: bypass read, L=1, D=2.
//  Interface and ordering are identical in both builds.
// STRUCTURE
//  Shared package core_pkg holds RESET_PC default, IMEM_AW=11, XLEN=32, and the NOP encoding 32'h00000013.
//  Sub-module fetch_buf: D-entry synchronous FIFO of {pc[31:0],instr[31:0]} with flush input.
//  Everything else lives in imem_fetch.
// TESTING
//  Memory model preloaded with word[i] = 32'hA000_0000+i.
//  1 Release reset, if_ready=1: if_valid rises at cycle L+1; if_pc 0,4,8... with instr A0000000,A0000001... every cycle.
//  2 Hold if_ready=0 for 5 cycles mid-stream:
//    if_pc/if_instr frozen; imem_ce low once occ+inflight=D; on resume the sequence continues without gap or repeat.
//  3 Full FIFO with a request in flight, redirect_pc=0x43:
//    stale words dropped; if_valid low L+1 cycles; next if_pc=0x40, instr=A0000010.
//  4 Redirect to 0x1FFC (ADDR_W=11): if_pc 0x1FFC then 0x2000; imem_ad 0x7FF then 0x000; instr A00007FF, A0000000.
//  5 Reset for 1 cycle while the FIFO is full:
//    if_valid=0 and imem_ce=0 during reset; fetch restarts at RESET_PC; no stale word is ever presented.
//  6 IFETCH_OREG_EN build, repeat scenarios 1 and 3: first valid at cycle 3, still 1 word/cycle, redirect gap 3 cycles.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants and the fetch-buffer entry type.
// IFETCH_OREG_EN selects the pipelined (output-registered) imem read.
package core_pkg;

  localparam int XLEN = 32;
  localparam int IMEM_AW = 11;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_OREG_EN
  localparam int IF_LAT = 2;
`else
  localparam int IF_LAT = 1;
`endif

  localparam int IF_DEPTH = IF_LAT + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_buf.sv
// Shifting synchronous FIFO of fetched {pc,instr}; head is a register.
// Depth follows the imem read latency (IFETCH_OREG_EN).
module fetch_buf
  import core_pkg::*;
#(
  parameter int D  = IF_DEPTH,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_ent_t    i_din,
  input  logic          i_pop,
  output fetch_ent_t    o_head,
  output logic [CW-1:0] o_cnt
);

  fetch_ent_t    r_mem [D];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_wr;

  assign w_wr   = r_cnt - CW'(i_pop);
  assign o_head = r_mem[0];
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < D; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < D - 1; i++)
        if (i_pop)
          r_mem[i] <= r_mem[i+1];
      // write lands after the shift, so a push on pop fills the freed slot
      for (int i = 0; i < D; i++)
        if (i_push && (CW'(i) == w_wr))
          r_mem[i] <= i_din;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction-fetch requester for the BSRAM imem with redirect flush.
// IFETCH_OREG_EN selects read latency 2 (default 1).
module imem_fetch
  import core_pkg::*;
#(
  parameter int          ADDR_W   = IMEM_AW,
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_ce,
  output logic              imem_oce,
  output logic              imem_wre,
  output logic [ADDR_W-1:0] imem_ad,
  input  logic [31:0]       imem_dout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
);

  localparam int CW = $clog2(IF_DEPTH + 1);

  logic [31:0]       r_pc;
  logic [IF_LAT-1:0] r_infl;
  logic [31:0]       r_rpc [IF_LAT];

  logic [CW-1:0] w_occ;
  logic [2:0]    w_infl_cnt;
  logic [2:0]    w_need;
  logic          w_pop;
  logic          w_issue;
  logic          w_unused;
  fetch_ent_t    w_din;
  fetch_ent_t    w_head;

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < IF_LAT; i++)
      w_infl_cnt = w_infl_cnt + {2'b0, r_infl[i]};
  end

  assign w_need   = 3'(w_occ) + w_infl_cnt;
  assign if_valid = (w_occ != '0) && !reset;
  assign w_pop    = if_valid && if_ready;
  assign w_issue  = !reset && !redirect_valid &&
                    (w_need < 3'(IF_DEPTH) + {2'b0, w_pop});

  assign imem_ce  = w_issue;
  assign imem_oce = 1'b1;
  assign imem_wre = 1'b0;
  assign imem_ad  = r_pc[ADDR_W+1:2];
  assign w_unused = ^redirect_pc[1:0];

  assign w_din.pc    = r_rpc[IF_LAT-1];
  assign w_din.instr = imem_dout;
  assign if_pc       = w_head.pc;
  assign if_instr    = w_head.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_infl <= '0;
      for (int i = 0; i < IF_LAT; i++)
        r_rpc[i] <= '0;
    end else if (redirect_valid) begin
      r_pc   <= {redirect_pc[31:2], 2'b00};
      r_infl <= '0;
    end else begin
      r_infl[0] <= w_issue;
      r_rpc[0]  <= r_pc;
      for (int i = 1; i < IF_LAT; i++) begin
        r_infl[i] <= r_infl[i-1];
        r_rpc[i]  <= r_rpc[i-1];
      end
      if (w_issue)
        r_pc <= r_pc + 32'd4;
    end
  end

  fetch_buf #(.D(IF_DEPTH), .CW(CW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (r_infl[IF_LAT-1]),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_cnt   (w_occ)
  );

endmodule
